// File: rtl/mac_tree_acc_if.sv
// mac_tree_acc_if: beat/result bundle for the dot-product engine
// master drives in_valid/in_first/in_last/signed_mode/a/b and receives out_valid/out/sat;
// slave is the engine side.
interface mac_tree_acc_if #(
  parameter int BW = 8,
  parameter int PR = 8,
  parameter int BW_PSUM = 24
);
  logic               in_valid;
  logic               in_first;
  logic               in_last;
  logic               signed_mode;
  logic [PR*BW-1:0]   a;
  logic [PR*BW-1:0]   b;
  logic               out_valid;
  logic [BW_PSUM-1:0] out;
  logic               sat;
  modport master (
    output in_valid, in_first, in_last, signed_mode, a, b,
    input  out_valid, out, sat
  );
  modport slave (
    input  in_valid, in_first, in_last, signed_mode, a, b,
    output out_valid, out, sat
  );
endinterface

// File: rtl/mac_tree_acc.sv
// mac_tree_acc: pipelined PR-lane signed/unsigned dot product with framed streaming accumulator
// Ports: clk, reset (sync, active-high), bus (mac_tree_acc_if.slave: beat in, result out).
// Latency from beat to out_valid is $clog2(PR)+2 cycles, one beat per cycle.
// Define MAC_TREE_SAT_EN to clamp the accumulator and report sat; otherwise it wraps and sat=0.
module mac_tree_acc #(
  parameter int BW = 8,
  parameter int PR = 8,
  parameter int BW_PSUM = 24
) (
  input logic           clk,
  input logic           reset,
  mac_tree_acc_if.slave bus
);
  localparam int L = $clog2(PR);
  localparam int W = BW_PSUM;
  function automatic logic [W-1:0] ext(input logic [BW-1:0] x, input logic s);
    return {{(W-BW){s & x[BW-1]}}, x};
  endfunction
  logic [L:0]   v_q, f_q, l_q;
  logic [W-1:0] prod_d [PR];
  // heap layout: leaves PR..2PR-1 hold products, node n sums children 2n and 2n+1, root is 1
  logic [W-1:0] node_q [1:2*PR-1];
  logic [W-1:0] acc_q, acc_d, base, out_q;
  logic         out_valid_q, sat_q, sat_d;
`ifdef MAC_TREE_SAT_EN
  logic [L:0]   m_q;
  logic [W:0]   sum_w;
  logic         ovf, pin, pin_q;
`endif
  always_comb
    for (int i = 0; i < PR; i++)
      prod_d[i] = ext(bus.a[BW*i +: BW], bus.signed_mode) * ext(bus.b[BW*i +: BW], bus.signed_mode);
  always_ff @(posedge clk) begin
    for (int i = 0; i < PR; i++) node_q[PR+i] <= prod_d[i];
    for (int n = 1; n < PR; n++) node_q[n] <= node_q[2*n] + node_q[2*n+1];
    f_q <= {f_q[L-1:0], bus.in_first};
    l_q <= {l_q[L-1:0], bus.in_last};
`ifdef MAC_TREE_SAT_EN
    m_q <= {m_q[L-1:0], bus.signed_mode};
`endif
  end
  always_ff @(posedge clk)
    if (reset) v_q <= '0;
    else v_q <= {v_q[L-1:0], bus.in_valid};
  always_comb begin
    base = f_q[L] ? '0 : acc_q;
`ifdef MAC_TREE_SAT_EN
    sum_w = m_q[L] ? {base[W-1], base} + {node_q[1][W-1], node_q[1]} : {1'b0, base} + {1'b0, node_q[1]};
    ovf = m_q[L] ? sum_w[W] ^ sum_w[W-1] : sum_w[W];
    // a clamped accumulator stays pinned until a first beat reopens the frame
    pin = pin_q & ~f_q[L];
    sat_d = pin | ovf;
    acc_d = pin ? acc_q : !ovf ? sum_w[W-1:0] : !m_q[L] ? '1 : sum_w[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`else
    sat_d = 1'b0;
    acc_d = base + node_q[1];
`endif
  end
  always_ff @(posedge clk)
    if (reset) begin
      acc_q <= '0;
      out_q <= '0;
      out_valid_q <= 1'b0;
      sat_q <= 1'b0;
`ifdef MAC_TREE_SAT_EN
      pin_q <= 1'b0;
`endif
    end else begin
      out_valid_q <= v_q[L] & l_q[L];
      if (v_q[L]) begin
        acc_q <= l_q[L] ? '0 : acc_d;
        if (l_q[L]) out_q <= acc_d;
        sat_q <= l_q[L] ? sat_d : f_q[L] ? 1'b0 : sat_q;
`ifdef MAC_TREE_SAT_EN
        pin_q <= ~l_q[L] & sat_d;
`endif
      end
    end
  assign bus.out = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sat = sat_q;
endmodule

// File: tb/tb_mac_tree_acc.sv
// tb_mac_tree_acc: directed self-checking bench for mac_tree_acc (PR=8, BW=8, BW_PSUM=24)
module tb_mac_tree_acc;
  localparam int BW = 8, PR = 8, BP = 24, LAT = 5;
  logic clk = 1'b0, reset = 1'b1;
  int cyc = 0, checks = 0, errors = 0;
  logic [BP-1:0] q_out[$];
  logic q_sat[$];
  int q_cyc[$];
  int bc, bcs[10];
  mac_tree_acc_if #(.BW(BW), .PR(PR), .BW_PSUM(BP)) bus ();
  mac_tree_acc #(.BW(BW), .PR(PR), .BW_PSUM(BP)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (bus.out_valid) begin
      q_out.push_back(bus.out);
      q_sat.push_back(bus.sat);
      q_cyc.push_back(cyc);
    end
  function automatic logic [PR*BW-1:0] rep(input logic [BW-1:0] x);
    return {PR{x}};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic beat(input logic f, input logic l, input logic m, input logic [PR*BW-1:0] av, input logic [PR*BW-1:0] bv);
    bus.in_valid = 1'b1;
    bus.in_first = f;
    bus.in_last = l;
    bus.signed_mode = m;
    bus.a = av;
    bus.b = bv;
    bc = cyc;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic get_res(input string tag, input logic [BP-1:0] eo, input logic es, input int ec);
    int n = 0;
    while (q_cyc.size() == 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " present"}, 64'(q_cyc.size() != 0), 64'd1);
    if (q_cyc.size() != 0) begin
      chk({tag, " out"}, 64'(q_out.pop_front()), 64'(eo));
      chk({tag, " sat"}, 64'(q_sat.pop_front()), 64'(es));
      chk({tag, " cycle"}, 64'(q_cyc.pop_front()), 64'(ec));
    end
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last = 1'b0;
    bus.signed_mode = 1'b0;
    bus.a = '0;
    bus.b = '0;
    idle(3);
    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset out", 64'(bus.out), 64'd0);
    chk("reset sat", 64'(bus.sat), 64'd0);
    reset = 1'b0;
    idle(2);
    beat(1, 1, 1, rep(8'd1), rep(8'd1));
    get_res("ones", 24'd8, 1'b0, bc + LAT);
    beat(1, 1, 1, rep(8'hFF), rep(8'd2));
    get_res("neg signed", 24'hFFFFF0, 1'b0, bc + LAT);
    beat(1, 1, 0, rep(8'hFF), rep(8'd2));
    get_res("unsigned", 24'd4080, 1'b0, bc + LAT);
    beat(1, 0, 1, rep(8'd3), rep(8'hFE));
    idle(2);
    beat(0, 0, 1, rep(8'd3), rep(8'hFE));
    idle(2);
    beat(0, 1, 1, rep(8'd3), rep(8'hFE));
    get_res("3beat", 24'hFFFF70, 1'b0, bc + LAT);
    idle(10);
    chk("3beat single pulse", 64'(q_cyc.size()), 64'd0);
    for (int k = 0; k < 10; k++) begin
      beat(1, 1, 1, rep(8'(k + 1)), rep(8'(k - 5)));
      bcs[k] = bc;
    end
    for (int k = 0; k < 10; k++)
      get_res($sformatf("b2b%0d", k), 24'((k + 1) * (k - 5) * 8), 1'b0, bcs[k] + LAT);
    for (int k = 0; k < 64; k++)
      beat(k == 0, k == 63, 1, rep(8'h80), rep(8'h80));
`ifdef MAC_TREE_SAT_EN
    get_res("64beat", 24'd8388607, 1'b1, bc + LAT);
`else
    get_res("64beat", 24'h800000, 1'b0, bc + LAT);
`endif
    beat(1, 1, 1, rep(8'd1), rep(8'd1));
    idle(1);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(10);
    chk("reset flush no result", 64'(q_cyc.size()), 64'd0);
    chk("reset flush out", 64'(bus.out), 64'd0);
    chk("reset flush out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset flush sat", 64'(bus.sat), 64'd0);
    beat(0, 1, 1, rep(8'd1), rep(8'd1));
    get_res("post reset", 24'd8, 1'b0, bc + LAT);
    idle(10);
    chk("no stray results", 64'(q_cyc.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_tree_acc.md
# mac_tree_acc

Parametrised, fully pipelined signed/unsigned dot-product engine with a streaming accumulator. Each valid beat multiplies PR element pairs and reduces them through a registered binary adder tree. The tree sum is then folded into a running accumulator framed by first/last flags. The block sits in the PE/array datapath where the fixed 8-input MAC was used, and adds generic lane count, mode select, multi-beat accumulation and a valid handshake.

## Interface
- BW, 8, element width of a and b
- PR, 8, lanes per beat; power of two, 2..64
- BW_PSUM, 24, tree/accumulator/output width; must be >= 2*BW+$clog2(PR)+1
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  beat present on a/b/flags this cycle
- in_first  in  1  beat opens a new dot product (accumulator restarts from this beat)
- in_last  in  1  beat closes the dot product; result emitted
- signed_mode  in  1  1: a,b two's complement; 0: unsigned; sampled per beat
- a  in  PR*BW  lane i = a[BW*(i+1)-1:BW*i]
- b  in  PR*BW  lane i = b[BW*(i+1)-1:BW*i]
- out_valid  out  1  one-cycle pulse, result on out
- out  out  BW_PSUM  dot-product result, held until next out_valid
- sat  out  1  result of current out saturated (only with macro, else 0)

## Operation
- No backpressure: one beat accepted every cycle that in_valid=1; in_valid=0 inserts a bubble.
- Stage M (1 cycle): per lane product of extended operands. signed_mode=1 sign-extends; 0 zero-extends. Each product is extended to BW_PSUM by the same rule.
- Stages T1..TL, L=$clog2(PR): pairwise registered adds, PR/2^k sums at level k, modulo 2^BW_PSUM.
- Stage A (1 cycle, on valid tree output):
  - in_first=1: acc <= tree_sum.
  - in_first=0: acc <= acc + tree_sum.
  - in_last=1: out <= new acc value; out_valid pulses; acc is treated as 0 for the next beat.
- first and last both 1: single-beat dot product, out = tree_sum.
- Non-first beat after a completed result, or after reset: accumulates from 0.
- Flags and signed_mode travel with their beat through a valid shift register; bubbles do not disturb acc.
- Mode may change every beat; mixed-mode beats within one dot product are legal, each summed under its own mode.
- Reset clears all pipeline valids, acc=0, out=0, out_valid=0, sat=0. Beats in flight at reset are discarded; no out_valid from them.

## Timing
- Latency: beat with in_last at cycle t gives out_valid at t+L+2. PR=8: 5 cycles. PR=2: 3 cycles.
- Throughput: 1 beat/cycle. Back-to-back dot products (last at t, first at t+1) produce out_valid at consecutive cycles.
- out_valid is registered; out changes only in cycles where out_valid=1.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- MAC_TREE_SAT_EN defined:
  - Stage A add is done at BW_PSUM+1 bits and clamped to [-2^(BW_PSUM-1), 2^(BW_PSUM-1)-1] in signed mode (unsigned: [0, 2^BW_PSUM-1]).
  - Once clamped, acc stays pinned for the rest of the dot product.
  - sat=1 alongside the out_valid pulse if any clamp occurred in that dot product; it clears when the next dot product starts.
- MAC_TREE_SAT_EN undefined: acc wraps modulo 2^BW_PSUM; sat tied 0.

## Test plan
- PR=8, signed, all lanes a=1, b=1, first=last=1 -> out=8, out_valid exactly 5 cycles after the beat.
- Signed a=0xFF (-1), b=2 all lanes -> out=-16 (0xFFFFF0). Same data unsigned -> out=4080.
- 3-beat dot product (first, mid, last) with 2 bubbles between beats; each beat has lanes a=3, b=-2 -> out=-144, one out_valid only.
- Back-to-back single-beat results every cycle for 10 cycles, varying data -> 10 consecutive out_valid pulses, each matching its own beat, with no cross-contamination.
- 64 signed beats of a=b=-128 (131072 per beat):
  - with MAC_TREE_SAT_EN: out=8388607, sat=1.
  - without: out=0x800000, sat=0.
- Assert reset 2 cycles after a last beat -> no out_valid, out=0. A subsequent non-first single beat a=b=1 with last=1 -> out=8.
